hrange_arbiter: RTL

- Shares one hrange generator instance among N_CLIENTS requesters.
- Each requester submits (base, limit, step). The arbiter grants in round-robin order, pulses the generator start, and forwards the generator's valid/ready output stream to the owning client until the generator reports done.
- Sits between the client FSMs and a single hrange datapath, so the design needs only one generator.

---
 rtl/hrange_pkg.sv | 36 +++
 rtl/rr_pick.sv | 23 ++
 rtl/hrange_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/hrange_pkg.sv
// rtl/hrange_pkg.sv - shared types and round-robin helper for the hrange arbiter
package hrange_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_CLIENTS   = 8;
  localparam int IDX_W         = 3;

  // First set request at or after ptr, wrapping at n; returns ptr when nothing is set.
  function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_CLIENTS-1:0] req,
                                               input logic [IDX_W-1:0]       ptr,
                                               input int                     n);
    logic [IDX_W-1:0]       pick;
    logic                   found;
    logic [MAX_CLIENTS-1:0] req_sh;
    int                     idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < MAX_CLIENTS; k++) begin
      idx    = (int'(ptr) + k) % n;
      req_sh = req >> idx;
      if (k < n && !found && req_sh[0]) begin
        pick  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector over the request vector
module rr_pick
  import hrange_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any
);

  logic [MAX_CLIENTS-1:0] w_req;

  always_comb begin
    w_req        = '0;
    w_req[N-1:0] = i_req;
  end

  assign o_grant = rr_next(w_req, i_ptr, N);
  assign o_any   = |i_req;

endmodule

// File: rtl/hrange_arbiter.sv
// rtl/hrange_arbiter.sv - round-robin sharing of one hrange generator among N clients
module hrange_arbiter
  import hrange_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int WIDTH     = DEFAULT_WIDTH
) (
  input  logic                       _clock,
  input  logic                       _reset_n,
  input  logic [N_CLIENTS-1:0]       req_valid,
  input  logic [N_CLIENTS*WIDTH-1:0] req_base,
  input  logic [N_CLIENTS*WIDTH-1:0] req_limit,
  input  logic [N_CLIENTS*WIDTH-1:0] req_step,
  output logic [N_CLIENTS-1:0]       req_ready,
  output logic [N_CLIENTS-1:0]       out_valid,
  input  logic [N_CLIENTS-1:0]       out_ready,
  output logic [WIDTH-1:0]           out_0,
  output logic [WIDTH-1:0]           out_1,
  output logic [N_CLIENTS-1:0]       out_done,
  output logic                       gen_reset,
  output logic                       gen_start,
  output logic                       gen_ready,
  output logic [WIDTH-1:0]           gen_base,
  output logic [WIDTH-1:0]           gen_limit,
  output logic [WIDTH-1:0]           gen_step,
  input  logic                       gen_valid,
  input  logic                       gen_done,
  input  logic [WIDTH-1:0]           gen_0,
  input  logic [WIDTH-1:0]           gen_1
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic               r_stretch;
  logic               r_gen_reset;
  logic [WIDTH-1:0]   r_base;
  logic [WIDTH-1:0]   r_limit;
  logic [WIDTH-1:0]   r_step;

  logic [IDX_W-1:0]   w_grant;
  logic               w_any;
  logic               w_accept;
  logic               w_run;
  logic               w_owner_ready;
  logic [N_CLIENTS-1:0] w_owner_oh;

  rr_pick #(.N(N_CLIENTS)) u_rr_pick (
    .i_req  (req_valid),
    .i_ptr  (r_rr_ptr),
    .o_grant(w_grant),
    .o_any  (w_any)
  );

  // No grant while the generator is still being held in reset.
  assign w_accept      = (r_state == ST_IDLE) && !r_gen_reset && w_any;
  assign w_run         = (r_state == ST_RUN);
  assign w_owner_oh    = N_CLIENTS'(1) << r_owner;
  assign w_owner_ready = |(out_ready & w_owner_oh);

  assign req_ready = w_accept ? (N_CLIENTS'(1) << w_grant) : '0;
  assign out_valid = (w_run && gen_valid) ? w_owner_oh : '0;
  assign out_done  = (r_state == ST_DONE) ? w_owner_oh : '0;
  assign out_0     = w_run ? gen_0 : '0;
  assign out_1     = w_run ? gen_1 : '0;
  assign gen_reset = r_gen_reset;
  assign gen_start = (r_state == ST_START);
  assign gen_ready = w_run && w_owner_ready;
  assign gen_base  = r_base;
  assign gen_limit = r_limit;
  assign gen_step  = r_step;

  // Two-stage stretch keeps gen_reset high for a full cycle after release.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_stretch   <= 1'b1;
      r_gen_reset <= 1'b1;
      r_base      <= '0;
      r_limit     <= '0;
      r_step      <= '0;
    end else begin
      r_stretch   <= 1'b0;
      r_gen_reset <= r_stretch;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant;
            r_base  <= req_base[int'(w_grant)*WIDTH +: WIDTH];
            r_limit <= req_limit[int'(w_grant)*WIDTH +: WIDTH];
            r_step  <= req_step[int'(w_grant)*WIDTH +: WIDTH];
            r_state <= ST_START;
          end
        end
        ST_START: r_state <= ST_RUN;
        ST_RUN: begin
          if (gen_done && w_owner_ready) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_rr_ptr <= (r_owner == IDX_W'(N_CLIENTS - 1)) ? '0 : r_owner + 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
